// File: rtl/hazard_controller_if.sv
// Pipeline hazard bundle: ID/EXE/MEM operand info and memory handshake in,
// stall/freeze/flush controls and status out.
interface hazard_controller_if;
   logic        fwdEn;
   logic [4:0]  IDRegsrc1;
   logic [4:0]  IDRegsrc2;
   logic        IDTwoSrc;
   logic [4:0]  EXERegDest;
   logic        EXERegWBen;
   logic        EXEMemREn;
   logic [4:0]  MEMRegDest;
   logic        MEMRegWBen;
   logic        branchTaken;
   logic        memReq;
   logic        memReady;
   logic        hazardStall;
   logic        pipeFreeze;
   logic        flush;
   logic [15:0] stallCount;
   logic        memTimeout;

   modport slave (
      input  fwdEn, IDRegsrc1, IDRegsrc2, IDTwoSrc,
      input  EXERegDest, EXERegWBen, EXEMemREn,
      input  MEMRegDest, MEMRegWBen,
      input  branchTaken, memReq, memReady,
      output hazardStall, pipeFreeze, flush, stallCount, memTimeout
   );

   modport master (
      output fwdEn, IDRegsrc1, IDRegsrc2, IDTwoSrc,
      output EXERegDest, EXERegWBen, EXEMemREn,
      output MEMRegDest, MEMRegWBen,
      output branchTaken, memReq, memReady,
      input  hazardStall, pipeFreeze, flush, stallCount, memTimeout
   );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: RAW stall detection, memory-wait freeze with
// timeout, branch flush, and a saturating stall counter.
//
// state   | meaning
// RUN     | pipeline flowing; freezes only while a new memory access is not ready
// MEMWAIT | memory access outstanding; whole pipeline frozen until memReady
module hazard_controller (
   input  logic               clk,
   input  logic               rst,
   hazard_controller_if.slave hz
);

   typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] stall_count_q, stall_count_d;
   logic        mem_timeout_q, mem_timeout_d;

   logic        exe_match;
   logic        mem_match;
   logic        raw_hazard;
   logic        freeze_c;
   logic        flush_c;
   logic        stall_c;

   // Register 0 is hardwired, so it never creates a dependency.
   always_comb begin
      exe_match = ((hz.IDRegsrc1 != 5'd0) && (hz.IDRegsrc1 == hz.EXERegDest)) ||
                  (hz.IDTwoSrc && (hz.IDRegsrc2 != 5'd0) && (hz.IDRegsrc2 == hz.EXERegDest));
      mem_match = ((hz.IDRegsrc1 != 5'd0) && (hz.IDRegsrc1 == hz.MEMRegDest)) ||
                  (hz.IDTwoSrc && (hz.IDRegsrc2 != 5'd0) && (hz.IDRegsrc2 == hz.MEMRegDest));
      if (hz.fwdEn) begin
         raw_hazard = hz.EXEMemREn && hz.EXERegWBen && exe_match;
      end else begin
         raw_hazard = (exe_match && hz.EXERegWBen) || (mem_match && hz.MEMRegWBen);
      end
   end

   always_comb begin
      freeze_c = 1'b0;
      flush_c  = 1'b0;
      stall_c  = 1'b0;
      if (!rst) begin
         if (state_q == RUN) begin
            freeze_c = hz.memReq && !hz.memReady;
         end else begin
            freeze_c = !hz.memReady;
         end
         flush_c = hz.branchTaken && !freeze_c;
         stall_c = raw_hazard && !freeze_c && !hz.branchTaken;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      stall_count_d = stall_count_q;
      mem_timeout_d = mem_timeout_q;

      case (state_q)
         RUN: begin
            if (hz.memReq && !hz.memReady) begin
               state_d    = MEMWAIT;
               wait_cnt_d = 8'd0;
            end
         end
         MEMWAIT: begin
            if (hz.memReady) begin
               state_d = RUN;
            end else if (wait_cnt_q != 8'hFF) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         default: state_d = RUN;
      endcase

      // Sticky: once the wait ever saturates, only reset clears it.
      if (state_q == MEMWAIT && wait_cnt_d == 8'hFF) begin
         mem_timeout_d = 1'b1;
      end

      if (stall_c && stall_count_q != 16'hFFFF) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         wait_cnt_q    <= 8'd0;
         stall_count_q <= 16'd0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         stall_count_q <= stall_count_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign hz.hazardStall = stall_c;
   assign hz.pipeFreeze  = freeze_c;
   assign hz.flush       = flush_c;
   assign hz.stallCount  = stall_count_q;
   assign hz.memTimeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller; expectations queued at drive time and
// popped when outputs are sampled.
module tb_hazard_controller;

   logic clk;
   logic rst;

   hazard_controller_if hz_if ();

   hazard_controller dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] model_cnt = 16'd0;

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push(string tag, logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic cmp(logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty observed=%0h expected=queued_value", obs);
      end else begin
         e = sb.pop_front();
         n_cmp++;
         assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   // Inputs already driven at a negedge; check outputs, cross one edge, check count.
   task automatic step(string tag, logic es, logic ef, logic efl);
      push({tag, "_stall"}, {31'd0, es});
      push({tag, "_freeze"}, {31'd0, ef});
      push({tag, "_flush"}, {31'd0, efl});
      #1;
      cmp({31'd0, hz_if.hazardStall});
      cmp({31'd0, hz_if.pipeFreeze});
      cmp({31'd0, hz_if.flush});
      if (es && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      @(negedge clk);
      push({tag, "_cnt"}, {16'd0, model_cnt});
      cmp({16'd0, hz_if.stallCount});
   endtask

   task automatic clear_inputs();
      hz_if.fwdEn       = 1'b0;
      hz_if.IDRegsrc1   = 5'd0;
      hz_if.IDRegsrc2   = 5'd0;
      hz_if.IDTwoSrc    = 1'b0;
      hz_if.EXERegDest  = 5'd0;
      hz_if.EXERegWBen  = 1'b0;
      hz_if.EXEMemREn   = 1'b0;
      hz_if.MEMRegDest  = 5'd0;
      hz_if.MEMRegWBen  = 1'b0;
      hz_if.branchTaken = 1'b0;
      hz_if.memReq      = 1'b0;
      hz_if.memReady    = 1'b0;
   endtask

   task automatic load_use();
      hz_if.fwdEn      = 1'b1;
      hz_if.EXEMemREn  = 1'b1;
      hz_if.EXERegWBen = 1'b1;
      hz_if.EXERegDest = 5'd5;
      hz_if.IDRegsrc1  = 5'd5;
   endtask

   task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp_v);
      push(tag, exp_v);
      cmp(obs);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      model_cnt = 16'd0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      load_use();
      hz_if.branchTaken = 1'b1;
      hz_if.memReq      = 1'b1;
      #2;
      check_val("rst_stall", {31'd0, hz_if.hazardStall}, 32'd0);
      check_val("rst_freeze", {31'd0, hz_if.pipeFreeze}, 32'd0);
      check_val("rst_flush", {31'd0, hz_if.flush}, 32'd0);
      check_val("rst_cnt", {16'd0, hz_if.stallCount}, 32'd0);
      check_val("rst_timeout", {31'd0, hz_if.memTimeout}, 32'd0);
      @(negedge clk);
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Load-use with forwarding
      load_use();
      step("loaduse", 1'b1, 1'b0, 1'b0);
      hz_if.EXEMemREn = 1'b0;
      step("fwd_nonload", 1'b0, 1'b0, 1'b0);
      hz_if.EXEMemREn = 1'b1;
      hz_if.IDRegsrc1 = 5'd0;
      hz_if.EXERegDest = 5'd0;
      step("fwd_r0", 1'b0, 1'b0, 1'b0);

      // No forwarding: MEM-stage match on src2
      clear_inputs();
      hz_if.MEMRegWBen = 1'b1;
      hz_if.MEMRegDest = 5'd7;
      hz_if.IDRegsrc2  = 5'd7;
      hz_if.IDTwoSrc   = 1'b1;
      step("nofwd_mem_src2", 1'b1, 1'b0, 1'b0);
      hz_if.IDTwoSrc = 1'b0;
      step("nofwd_onesrc", 1'b0, 1'b0, 1'b0);
      hz_if.IDTwoSrc   = 1'b1;
      hz_if.MEMRegDest = 5'd0;
      hz_if.IDRegsrc2  = 5'd0;
      step("nofwd_r0", 1'b0, 1'b0, 1'b0);
      clear_inputs();
      hz_if.EXERegWBen = 1'b1;
      hz_if.EXERegDest = 5'd12;
      hz_if.IDRegsrc1  = 5'd12;
      step("nofwd_exe", 1'b1, 1'b0, 1'b0);
      hz_if.EXERegWBen = 1'b0;
      step("nofwd_exe_nowb", 1'b0, 1'b0, 1'b0);

      // Memory wait of three frozen cycles
      clear_inputs();
      hz_if.memReq = 1'b1;
      step("mw_run", 1'b0, 1'b1, 1'b0);
      step("mw_wait1", 1'b0, 1'b1, 1'b0);
      step("mw_wait2", 1'b0, 1'b1, 1'b0);
      hz_if.memReady = 1'b1;
      step("mw_ready", 1'b0, 1'b0, 1'b0);
      clear_inputs();
      step("mw_back_run", 1'b0, 1'b0, 1'b0);
      hz_if.memReady = 1'b1;
      step("ready_noreq", 1'b0, 1'b0, 1'b0);
      hz_if.memReady = 1'b0;
      step("ready_noreq_after", 1'b0, 1'b0, 1'b0);
      hz_if.memReq   = 1'b1;
      hz_if.memReady = 1'b1;
      step("req_and_ready", 1'b0, 1'b0, 1'b0);
      clear_inputs();
      step("req_and_ready_after", 1'b0, 1'b0, 1'b0);

      // Priority: freeze > flush > stall
      load_use();
      hz_if.branchTaken = 1'b1;
      step("branch_over_stall", 1'b0, 1'b0, 1'b1);
      hz_if.memReq = 1'b1;
      step("freeze_over_all", 1'b0, 1'b1, 1'b0);
      hz_if.memReq   = 1'b0;
      hz_if.memReady = 1'b1;
      step("freeze_release", 1'b0, 1'b0, 1'b1);
      clear_inputs();
      step("prio_idle", 1'b0, 1'b0, 1'b0);

      // Memory timeout: set exactly when waitCnt reaches 255
      hz_if.memReq = 1'b1;
      step("to_entry", 1'b0, 1'b1, 1'b0);
      hz_if.memReq = 1'b0;
      repeat (254) @(negedge clk);
      #1;
      check_val("to_before", {31'd0, hz_if.memTimeout}, 32'd0);
      check_val("to_before_freeze", {31'd0, hz_if.pipeFreeze}, 32'd1);
      @(negedge clk);
      #1;
      check_val("to_at255", {31'd0, hz_if.memTimeout}, 32'd1);
      repeat (5) @(negedge clk);
      #1;
      check_val("to_held_freeze", {31'd0, hz_if.pipeFreeze}, 32'd1);
      check_val("to_held", {31'd0, hz_if.memTimeout}, 32'd1);
      @(negedge clk);
      hz_if.memReady = 1'b1;
      step("to_ready", 1'b0, 1'b0, 1'b0);
      hz_if.memReady = 1'b0;
      step("to_run", 1'b0, 1'b0, 1'b0);
      check_val("to_sticky", {31'd0, hz_if.memTimeout}, 32'd1);
      pulse_reset();
      check_val("to_cleared", {31'd0, hz_if.memTimeout}, 32'd0);

      // Stall counter saturation
      load_use();
      repeat (65534) @(negedge clk);
      check_val("cnt_fffe", {16'd0, hz_if.stallCount}, 32'h0000FFFE);
      @(negedge clk);
      check_val("cnt_ffff", {16'd0, hz_if.stallCount}, 32'h0000FFFF);
      repeat (70000 - 65535) @(negedge clk);
      model_cnt = 16'hFFFF;
      check_val("cnt_hold_stall", {31'd0, hz_if.hazardStall}, 32'd1);
      step("cnt_sat", 1'b1, 1'b0, 1'b0);

      // Reset in the middle of a memory wait
      hz_if.branchTaken = 1'b1;
      hz_if.memReq      = 1'b1;
      step("mwrst_entry", 1'b0, 1'b1, 1'b0);
      hz_if.memReq = 1'b0;
      step("mwrst_wait", 1'b0, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      model_cnt = 16'd0;
      #1;
      check_val("mwrst_stall", {31'd0, hz_if.hazardStall}, 32'd0);
      check_val("mwrst_freeze", {31'd0, hz_if.pipeFreeze}, 32'd0);
      check_val("mwrst_flush", {31'd0, hz_if.flush}, 32'd0);
      check_val("mwrst_cnt", {16'd0, hz_if.stallCount}, 32'd0);
      check_val("mwrst_timeout", {31'd0, hz_if.memTimeout}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      step("mwrst_resume_run", 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port fwdEn, input, 1; 1 means the forwarding unit is active.
REQ-004 SHALL have ports IDRegsrc1 and IDRegsrc2, input, 5 each, the ID-stage source registers.
REQ-005 SHALL have port IDTwoSrc, input, 1; 1 means the ID instruction reads IDRegsrc2.
REQ-006 SHALL have ports EXERegDest, input, 5; EXERegWBen, input, 1; EXEMemREn, input, 1 (EXE instruction is a load).
REQ-007 SHALL have ports MEMRegDest, input, 5; MEMRegWBen, input, 1.
REQ-008 SHALL have ports branchTaken, input, 1; memReq, input, 1 (MEM-stage load/store); memReady, input, 1 (SRAM done).
REQ-009 SHALL have port hazardStall, output, 1: hold PC and IF/ID, insert a bubble into ID/EXE.
REQ-010 SHALL have port pipeFreeze, output, 1: hold every pipeline register.
REQ-011 SHALL have port flush, output, 1: squash IF/ID.
REQ-012 SHALL have ports stallCount, output, 16; memTimeout, output, 1.

Function
REQ-013 SHALL treat a source as matching only when the register number is nonzero and equals the destination; IDRegsrc2 SHALL count only when IDTwoSrc=1.
REQ-014 With fwdEn=1, rawHazard SHALL be 1 iff EXEMemREn=1, EXERegWBen=1, and EXERegDest matches a source (load-use).
REQ-015 With fwdEn=0, rawHazard SHALL be 1 iff there is an EXE match with EXERegWBen=1, or a MEM match with MEMRegWBen=1.
REQ-016 SHALL implement a two-state FSM, RUN and MEMWAIT.
REQ-017 RUN to MEMWAIT SHALL occur when memReq=1 and memReady=0.
REQ-018 MEMWAIT to RUN SHALL occur on the edge where memReady=1.
REQ-019 pipeFreeze SHALL be combinational: 1 in RUN when memReq=1 and memReady=0; 1 in MEMWAIT while memReady=0; otherwise 0.
REQ-020 pipeFreeze SHALL be 0 in the same cycle memReady rises.
REQ-021 Priority SHALL be pipeFreeze, then flush, then hazardStall.
REQ-022 While pipeFreeze=1, flush and hazardStall SHALL be 0.
REQ-023 flush SHALL equal branchTaken and !pipeFreeze, combinationally, with no latency.
REQ-024 hazardStall SHALL equal rawHazard, !pipeFreeze and !branchTaken, so a squashed instruction never stalls.
REQ-025 stallCount SHALL increment by 1 on each edge where hazardStall=1, saturate at 16'hFFFF, and never wrap.
REQ-026 An 8-bit waitCnt SHALL clear on entry to MEMWAIT and increment each MEMWAIT cycle with memReady=0.
REQ-027 When waitCnt reaches 255, memTimeout SHALL set and stay set (sticky) until rst.
REQ-028 waitCnt SHALL saturate at 255, and the FSM SHALL stay in MEMWAIT until memReady.
REQ-029 memReady=1 while in RUN with memReq=0 SHALL be ignored.
REQ-030 Simultaneous memReq=1 with memReady=1 in RUN SHALL cause no freeze and SHALL stay in RUN.

Reset
REQ-031 rst=1 SHALL immediately force state RUN, waitCnt 0, stallCount 0, memTimeout 0.
REQ-032 rst=1 SHALL force hazardStall, pipeFreeze and flush to 0 regardless of inputs.
REQ-033 rst asserted in MEMWAIT SHALL abandon the wait; after release the block SHALL resume in RUN.

Verification
REQ-034 fwdEn=1, EXEMemREn=1, EXERegWBen=1, EXERegDest=5, IDRegsrc1=5 -> hazardStall=1 that cycle and stallCount goes 0 to 1; with EXEMemREn=0 -> hazardStall=0.
REQ-035 fwdEn=0, MEMRegWBen=1, MEMRegDest=7, IDRegsrc2=7: with IDTwoSrc=1 -> hazardStall=1; with IDTwoSrc=0 -> hazardStall=0; with all registers 0 -> no stall.
REQ-036 memReq=1, memReady=0 for 3 cycles, then memReady=1 -> pipeFreeze=1 for exactly 3 cycles, 0 in the ready cycle, state back to RUN.
REQ-037 Load-use hazard plus branchTaken=1 in the same cycle -> flush=1 and hazardStall=0; add a pending memory wait -> only pipeFreeze=1.
REQ-038 memReady held 0 for 260 cycles -> memTimeout=1 from wait cycle 255 and still 1 after memReady=1, until rst.
REQ-039 Hold a hazard for 70000 cycles -> stallCount=16'hFFFF and held there; a mid-MEMWAIT rst -> all outputs 0 and state RUN.
